// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - execute-stage branch resolve, PC redirect and IF/ID flush sequencer
// Optional BRANCH_STATS_EN adds saturating resolved/taken counters.
module branch_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_imm,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [2:0]      req_fun3,
  input  logic            req_jal,
  input  logic            req_jalr,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            busy,
  output logic            exc_misalign,
`ifdef BRANCH_STATS_EN
  output logic [31:0]     stat_resolved,
  output logic [31:0]     stat_taken,
`endif
  output logic            exc_illegal
);

  typedef enum logic [1:0] {IDLE, RESOLVE, FLUSH} state_t;

  state_t          state, state_nx;
  logic [3:0]      cnt_q, cnt_nx;
  logic [XLEN-1:0] pc_q, imm_q, rs1_q, rs2_q;
  logic [2:0]      fun3_q;
  logic            jal_q, jalr_q;

  logic            accept, cond, illegal, taken, misaligned, resolving, do_redirect;
  logic [XLEN-1:0] sum_pc, sum_rs, target;

  assign req_ready = (state == IDLE) && !kill;
  assign accept    = req_valid && req_ready;

  always_comb begin
    cond = 1'b0;
    case (fun3_q)
      3'b000:  cond = (rs1_q == rs2_q);
      3'b001:  cond = (rs1_q != rs2_q);
      3'b100:  cond = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101:  cond = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  cond = (rs1_q <  rs2_q);
      3'b111:  cond = (rs1_q >= rs2_q);
      default: cond = 1'b0;
    endcase
    illegal = !jal_q && !jalr_q && (fun3_q[2:1] == 2'b01);
    taken   = jal_q || jalr_q || cond;
    sum_pc  = pc_q + imm_q;
    sum_rs  = rs1_q + imm_q;
    // jal wins over jalr when both flags are set
    target  = (jalr_q && !jal_q) ? (sum_rs & {{(XLEN-1){1'b1}}, 1'b0}) : sum_pc;
  end

  assign misaligned  = (target[1:0] != 2'b00);
  assign resolving   = (state == RESOLVE) && !kill;
  assign do_redirect = resolving && taken && !misaligned;

  assign redirect_valid = do_redirect;
  assign redirect_pc    = target;
  assign flush_if_id    = do_redirect || (state == FLUSH);
  assign busy           = (state != IDLE);
  assign exc_misalign   = resolving && taken && misaligned;
  assign exc_illegal    = resolving && illegal;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_q;
    if (kill) begin
      state_nx = IDLE;
      cnt_nx   = 4'd0;
    end else begin
      case (state)
        IDLE:    if (accept) state_nx = RESOLVE;
        RESOLVE: begin
          // the RESOLVE cycle already counts as the first flush cycle
          if (do_redirect && (FLUSH_CYCLES > 1)) begin
            state_nx = FLUSH;
            cnt_nx   = 4'(FLUSH_CYCLES - 1);
          end else begin
            state_nx = IDLE;
          end
        end
        FLUSH: begin
          cnt_nx = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt_q <= 4'd0;
    end else begin
      state <= state_nx;
      cnt_q <= cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      imm_q  <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      fun3_q <= 3'd0;
      jal_q  <= 1'b0;
      jalr_q <= 1'b0;
    end else if (accept) begin
      pc_q   <= req_pc;
      imm_q  <= req_imm;
      rs1_q  <= req_rs1;
      rs2_q  <= req_rs2;
      fun3_q <= req_fun3;
      jal_q  <= req_jal;
      jalr_q <= req_jalr;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved <= 32'd0;
      stat_taken    <= 32'd0;
    end else begin
      if (resolving && (stat_resolved != 32'hFFFF_FFFF)) stat_resolved <= stat_resolved + 32'd1;
      if (do_redirect && (stat_taken != 32'hFFFF_FFFF)) stat_taken <= stat_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - self-checking bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

  localparam int XLEN = 32;
  localparam int FC   = 2;

  logic            clk = 1'b0;
  logic            rst, kill, req_valid, req_ready;
  logic [XLEN-1:0] req_pc, req_imm, req_rs1, req_rs2, redirect_pc;
  logic [2:0]      req_fun3;
  logic            req_jal, req_jalr;
  logic            redirect_valid, flush_if_id, busy, exc_misalign, exc_illegal;
`ifdef BRANCH_STATS_EN
  logic [31:0]     stat_resolved, stat_taken;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .kill(kill),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_pc(req_pc), .req_imm(req_imm), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_fun3(req_fun3), .req_jal(req_jal), .req_jalr(req_jalr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if_id(flush_if_id), .busy(busy), .exc_misalign(exc_misalign),
`ifdef BRANCH_STATS_EN
    .stat_resolved(stat_resolved), .stat_taken(stat_taken),
`endif
    .exc_illegal(exc_illegal)
  );

  // Reference outcome of one op from the ISA rules
  task automatic model(input logic [31:0] pc, imm, rs1, rs2, input logic [2:0] f3,
                       input logic jal, jalr,
                       output logic [31:0] tgt, output logic redir, mis, ill);
    logic tk;
    longint sa, sb;
    sa = longint'($signed(rs1));
    sb = longint'($signed(rs2));
    ill = 1'b0;
    if (jal)       begin tk = 1'b1; tgt = pc + imm; end
    else if (jalr) begin tk = 1'b1; tgt = ((rs1 + imm) >> 1) << 1; end
    else begin
      tgt = pc + imm;
      if      (f3 == 3'd0) tk = (rs1 == rs2);
      else if (f3 == 3'd1) tk = (rs1 != rs2);
      else if (f3 == 3'd4) tk = (sa < sb);
      else if (f3 == 3'd5) tk = (sa >= sb);
      else if (f3 == 3'd6) tk = (rs1 < rs2);
      else if (f3 == 3'd7) tk = (rs1 >= rs2);
      else begin tk = 1'b0; ill = 1'b1; end
    end
    redir = tk && (tgt % 4 == 0);
    mis   = tk && (tgt % 4 != 0);
  endtask

  task automatic wait_ready(input string name);
    int w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    n_cmp++;
    if (!req_ready) begin n_bad++; $display("FAIL %s wait_ready: req_ready=%b required 1 within 50 cycles", name, req_ready); end
  endtask

  // Present one op at a negedge and check every cycle until the block is ready again
  task automatic run_op(input logic [31:0] pc, imm, rs1, rs2, input logic [2:0] f3,
                        input logic jal, jalr, input string name);
    logic [31:0] tgt;
    logic redir, mis, ill;
    model(pc, imm, rs1, rs2, f3, jal, jalr, tgt, redir, mis, ill);
    wait_ready(name);
    req_valid = 1'b1; req_pc = pc; req_imm = imm; req_rs1 = rs1; req_rs2 = rs2;
    req_fun3 = f3; req_jal = jal; req_jalr = jalr;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_rs1 = $urandom; req_rs2 = $urandom; req_pc = $urandom;
    #1;
    n_cmp++; if (redirect_valid !== redir) begin n_bad++; $display("FAIL %s redirect_valid: got %b want %b", name, redirect_valid, redir); end
    n_cmp++; if (exc_misalign !== mis) begin n_bad++; $display("FAIL %s exc_misalign: got %b want %b", name, exc_misalign, mis); end
    n_cmp++; if (exc_illegal !== ill) begin n_bad++; $display("FAIL %s exc_illegal: got %b want %b", name, exc_illegal, ill); end
    n_cmp++; if (flush_if_id !== redir) begin n_bad++; $display("FAIL %s flush_resolve: got %b want %b", name, flush_if_id, redir); end
    n_cmp++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_bad++; $display("FAIL %s busy/ready: got %b/%b want 1/0", name, busy, req_ready); end
    if (redir || mis) begin
      n_cmp++; if (redirect_pc !== tgt) begin n_bad++; $display("FAIL %s redirect_pc: got %h want %h", name, redirect_pc, tgt); end
    end
    if (redir) begin
      for (int k = 1; k < FC; k++) begin
        @(negedge clk); #1;
        n_cmp++;
        if (flush_if_id !== 1'b1 || redirect_valid !== 1'b0 || req_ready !== 1'b0) begin
          n_bad++; $display("FAIL %s flush_hold[%0d]: flush/redir/ready got %b/%b/%b want 1/0/0", name, k, flush_if_id, redirect_valid, req_ready);
        end
      end
    end
    @(negedge clk); #1;
    n_cmp++;
    if (req_ready !== 1'b1 || flush_if_id !== 1'b0 || busy !== 1'b0 || redirect_valid !== 1'b0) begin
      n_bad++; $display("FAIL %s return_idle: ready/flush/busy/redir got %b/%b/%b/%b want 1/0/0/0", name, req_ready, flush_if_id, busy, redirect_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; kill = 1'b0; req_valid = 1'b0;
    req_pc = '0; req_imm = '0; req_rs1 = '0; req_rs2 = '0; req_fun3 = 3'd0; req_jal = 1'b0; req_jalr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++;
    if ({redirect_valid, flush_if_id, busy, exc_misalign, exc_illegal} !== 5'b0 || redirect_pc !== 32'h0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset: rv/fl/busy/mis/ill=%b%b%b%b%b pc=%h ready=%b want 00000 0 1",
                        redirect_valid, flush_if_id, busy, exc_misalign, exc_illegal, redirect_pc, req_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(32'h100, 32'h20, 32'd5, 32'd5, 3'b000, 1'b0, 1'b0, "beq_taken");
    run_op(32'h300, 32'h8, 32'hFFFF_FFFF, 32'd1, 3'b100, 1'b0, 1'b0, "blt_signed");
    run_op(32'h300, 32'h8, 32'hFFFF_FFFF, 32'd1, 3'b110, 1'b0, 1'b0, "bltu_unsigned");
    run_op(32'h0, 32'h0, 32'h1003, 32'd0, 3'b000, 1'b0, 1'b1, "jalr_misalign");
    run_op(32'h0, 32'h0, 32'h1001, 32'd0, 3'b000, 1'b0, 1'b1, "jalr_aligned");
    run_op(32'hFFFF_FFF0, 32'h20, 32'd0, 32'd0, 3'b000, 1'b1, 1'b0, "jal_wrap");
    run_op(32'h400, 32'h10, 32'd1, 32'd1, 3'b011, 1'b0, 1'b0, "illegal_011");
    run_op(32'h400, 32'h10, 32'd1, 32'd2, 3'b010, 1'b0, 1'b0, "illegal_010");
    run_op(32'h500, 32'h6, 32'd3, 32'd4, 3'b001, 1'b0, 1'b0, "bne_misalign");
    run_op(32'h600, 32'h40, 32'h1003, 32'd0, 3'b000, 1'b1, 1'b1, "jal_over_jalr");
  endtask

  task automatic test_random();
    logic [31:0] pool [4] = '{32'd0, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 120; i++) begin
      logic [31:0] a, b, imm;
      logic j, jr;
      a   = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
      b   = ($urandom_range(0, 2) == 0) ? a : pool[$urandom_range(0, 3)];
      imm = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom_range(0, 255) << 2) - 32'd512;
      j   = ($urandom_range(0, 7) == 0);
      jr  = ($urandom_range(0, 7) == 0);
      run_op($urandom & 32'hFFFF_FFFC, imm, a, b, 3'($urandom_range(0, 7)), j, jr, "random");
    end
  endtask

  task automatic test_kill();
    wait_ready("kill_resolve");
    req_valid = 1'b1; req_pc = 32'h200; req_imm = 32'h40; req_rs1 = 32'd1; req_rs2 = 32'd2;
    req_fun3 = 3'b001; req_jal = 1'b0; req_jalr = 1'b0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; kill = 1'b1; #1;
    n_cmp++;
    if ({redirect_valid, flush_if_id, exc_misalign, exc_illegal, req_ready} !== 5'b0) begin
      n_bad++; $display("FAIL kill_resolve outputs: rv/fl/mis/ill/ready=%b%b%b%b%b want 00000", redirect_valid, flush_if_id, exc_misalign, exc_illegal, req_ready);
    end
    @(negedge clk); kill = 1'b0; #1;
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || flush_if_id !== 1'b0) begin
      n_bad++; $display("FAIL kill_resolve idle: busy/ready/flush=%b%b%b want 010", busy, req_ready, flush_if_id);
    end
    req_valid = 1'b1; req_fun3 = 3'b000; req_rs2 = 32'd1; kill = 1'b1; #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL kill_blocks_accept: req_ready=%b want 0", req_ready); end
    @(posedge clk); @(negedge clk); req_valid = 1'b0; kill = 1'b0; #1;
    n_cmp++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0) begin
      n_bad++; $display("FAIL kill_blocks_accept state: busy/rv=%b%b want 00", busy, redirect_valid);
    end
    req_valid = 1'b1; req_pc = 32'h800; req_imm = 32'h4; req_rs1 = 32'd9; req_rs2 = 32'd9; req_fun3 = 3'b000;
    @(posedge clk); @(negedge clk); req_valid = 1'b0; #1;
    n_cmp++; if (redirect_valid !== 1'b1) begin n_bad++; $display("FAIL kill_flush setup: redirect_valid=%b want 1", redirect_valid); end
    @(negedge clk); kill = 1'b1; #1;
    n_cmp++; if (flush_if_id !== 1'b1) begin n_bad++; $display("FAIL kill_flush same_cycle: flush=%b want 1", flush_if_id); end
    @(negedge clk); kill = 1'b0; #1;
    n_cmp++;
    if (flush_if_id !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL kill_flush after: flush/busy=%b%b want 00", flush_if_id, busy);
    end
  endtask

  task automatic test_rst_flush();
    wait_ready("rst_flush");
    req_valid = 1'b1; req_pc = 32'h900; req_imm = 32'h100; req_rs1 = 32'd3; req_rs2 = 32'd3;
    req_fun3 = 3'b101; req_jal = 1'b0; req_jalr = 1'b0;
    @(posedge clk); @(negedge clk); req_valid = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (flush_if_id !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL rst_flush setup: flush/busy=%b%b want 11", flush_if_id, busy); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++;
    if ({redirect_valid, flush_if_id, busy, exc_misalign, exc_illegal} !== 5'b0 || redirect_pc !== 32'h0) begin
      n_bad++; $display("FAIL rst_flush: rv/fl/busy/mis/ill=%b%b%b%b%b pc=%h want 00000 0",
                        redirect_valid, flush_if_id, busy, exc_misalign, exc_illegal, redirect_pc);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_kill();
    test_rst_flush();
    test_random();
    run_op(32'h100, 32'h20, 32'd5, 32'd5, 3'b000, 1'b0, 1'b0, "back_to_back_a");
    run_op(32'h104, 32'h8, 32'd5, 32'd6, 3'b000, 1'b0, 1'b0, "back_to_back_b");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
